// File: rtl/prbs_seq_pkg.sv
// Shared types and constants for the PRBS link frame sequencer.
package prbs_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        PAYLOAD = 2'd2,
        GAP     = 2'd3
    } seq_state_e;

    localparam int SLOT_BITS  = 32;
    localparam int SLOT_CNT_W = $clog2(SLOT_BITS);

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hA5A5_5A5A;
    localparam logic [31:0] DEFAULT_IDLE_WORD = 32'h0000_0000;

endpackage

// File: rtl/prbs_link_sequencer_slot_timer.sv
// Bit-position counter within a 32-bit word slot; flags the first and last bit.
module slot_timer
    import prbs_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic boundary,
    output logic last
);

    logic [SLOT_CNT_W-1:0] cnt_q;
    logic [SLOT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign boundary = (cnt_q == '0);
    assign last     = (cnt_q == '1);

endmodule

// File: rtl/prbs_link_sequencer.sv
// Frame sequencer for the PRBS test link: sync slots, PRBS payload slots, idle gap
// slots, with a registered load strobe and word for the 32:1 serializer.
module prbs_link_sequencer
    import prbs_seq_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
    parameter int          SYNC_SLOTS = 2,
    parameter int          GAP_SLOTS  = 1,
    parameter logic [31:0] IDLE_WORD  = DEFAULT_IDLE_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [7:0]  payload_len,
    input  logic [31:0] prbs_word,
    output logic        prbs_advance,
    output logic        load,
    output logic [31:0] word_out,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_count
);

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_SLOTS - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_SLOTS - 1);

    seq_state_e  state_q, state_d;
    logic [7:0]  state_slot_q, state_slot_d;
    logic [7:0]  len_q, len_d;
    logic        loop_q, loop_d;
    logic        stop_pend_q, stop_pend_d;
    logic        load_q, load_d;
    logic        adv_q, adv_d;
    logic [31:0] word_q, word_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  count_q, count_d;

    logic slot_boundary;
    logic slot_last;
    logic frame_end;

    slot_timer u_slot_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state_q == IDLE),
        .en       (state_q != IDLE),
        .boundary (slot_boundary),
        .last     (slot_last)
    );

    always_comb begin
        state_d      = state_q;
        state_slot_d = state_slot_q;
        len_d        = len_q;
        loop_d       = loop_q;
        stop_pend_d  = stop_pend_q;
        frame_end    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SYNC;
                    state_slot_d = 8'd0;
                    len_d        = payload_len;
                    loop_d       = loop_en;
                end
            end
            SYNC: begin
                if (slot_last) begin
                    if (state_slot_q == SYNC_LAST) begin
                        state_d      = PAYLOAD;
                        state_slot_d = 8'd0;
                    end else begin
                        state_slot_d = state_slot_q + 8'd1;
                    end
                end
            end
            PAYLOAD: begin
                if (slot_last) begin
                    if (state_slot_q == len_q) begin
                        state_d      = GAP;
                        state_slot_d = 8'd0;
                    end else begin
                        state_slot_d = state_slot_q + 8'd1;
                    end
                end
            end
            GAP: begin
                if (slot_last) begin
                    if (state_slot_q == GAP_LAST) begin
                        frame_end    = 1'b1;
                        state_slot_d = 8'd0;
                        if (loop_q && !stop_pend_q) begin
                            state_d = SYNC;
                            len_d   = payload_len;
                            loop_d  = loop_en;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_slot_d = state_slot_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stop arriving with start counts, so exactly one frame runs.
        if (stop && ((state_q != IDLE) || start)) begin
            stop_pend_d = 1'b1;
        end
        if (state_d == IDLE) begin
            stop_pend_d = 1'b0;
        end

        // Outputs are computed for the cycle after the edge, so they look at state_d.
        busy_d = (state_d != IDLE);
        load_d = busy_d && (slot_last || ((state_q == IDLE) && slot_boundary));
        word_d = word_q;
        if (load_d) begin
            case (state_d)
                SYNC:    word_d = SYNC_WORD;
                PAYLOAD: word_d = prbs_word;
                GAP:     word_d = IDLE_WORD;
                default: word_d = word_q;
            endcase
        end
        adv_d   = load_d && (state_d == PAYLOAD);
        done_d  = frame_end;
        count_d = frame_end ? count_q + 8'd1 : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            state_slot_q <= 8'd0;
            len_q        <= 8'd0;
            loop_q       <= 1'b0;
            stop_pend_q  <= 1'b0;
            load_q       <= 1'b0;
            adv_q        <= 1'b0;
            word_q       <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            count_q      <= 8'd0;
        end else begin
            state_q      <= state_d;
            state_slot_q <= state_slot_d;
            len_q        <= len_d;
            loop_q       <= loop_d;
            stop_pend_q  <= stop_pend_d;
            load_q       <= load_d;
            adv_q        <= adv_d;
            word_q       <= word_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            count_q      <= count_d;
        end
    end

    assign prbs_advance = adv_q;
    assign load         = load_q;
    assign word_out     = word_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
    assign frame_count  = count_q;

endmodule

// File: tb/tb_prbs_link_sequencer.sv
// Self-checking bench for prbs_link_sequencer: expected loads are queued as frames
// are launched and compared in order against the loads the DUT produces.
module tb_prbs_link_sequencer;

    localparam logic [31:0] SYNC_W = 32'hA5A5_5A5A;
    localparam logic [31:0] IDLE_W = 32'h0000_0000;
    localparam logic [31:0] SEED   = 32'h1234_5678;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [7:0]  payload_len;
    logic [31:0] prbs_word;
    logic        prbs_advance;
    logic        load;
    logic [31:0] word_out;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_count;

    typedef struct {
        int          cyc;
        logic [31:0] word;
        logic        adv;
    } load_t;

    load_t       exp_q[$];
    load_t       obs_q[$];
    int          done_q[$];
    int          cyc;
    int          busy_cycles;
    int          stray_adv;
    int          exp_next;
    logic [31:0] exp_prbs;
    int          pass_cnt;
    int          total_cnt;

    prbs_link_sequencer #(
        .SYNC_WORD  (32'hA5A5_5A5A),
        .SYNC_SLOTS (2),
        .GAP_SLOTS  (1),
        .IDLE_WORD  (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .payload_len  (payload_len),
        .prbs_word    (prbs_word),
        .prbs_advance (prbs_advance),
        .load         (load),
        .word_out     (word_out),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_count  (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] prbs_next(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[27] ^ x[1] ^ x[0]};
    endfunction

    // One clock: sample outputs 1ns after the edge and step the bench's generator.
    task automatic tick();
        load_t o;
        @(posedge clk);
        #1;
        cyc++;
        if (load) begin
            o.cyc  = cyc;
            o.word = word_out;
            o.adv  = prbs_advance;
            obs_q.push_back(o);
        end else if (prbs_advance) begin
            stray_adv++;
        end
        if (frame_done) done_q.push_back(cyc);
        if (busy) busy_cycles++;
        if (prbs_advance) prbs_word = prbs_next(prbs_word);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        done_q.delete();
        busy_cycles = 0;
        stray_adv   = 0;
        exp_next    = 1;
        cyc         = 0;
        prbs_word   = SEED;
        exp_prbs    = SEED;
    endtask

    task automatic push_frame(input int len);
        load_t e;
        for (int i = 0; i < 2; i++) begin
            e.cyc = exp_next; e.word = SYNC_W; e.adv = 1'b0;
            exp_q.push_back(e);
            exp_next += 32;
        end
        for (int i = 0; i <= len; i++) begin
            e.cyc = exp_next; e.word = exp_prbs; e.adv = 1'b1;
            exp_q.push_back(e);
            exp_prbs = prbs_next(exp_prbs);
            exp_next += 32;
        end
        e.cyc = exp_next; e.word = IDLE_W; e.adv = 1'b0;
        exp_q.push_back(e);
        exp_next += 32;
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        payload_len = 8'd0; prbs_word = SEED;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({load, prbs_advance, busy, frame_done} !== 4'b0000)
            $display("FAIL reset_strobes: got load/adv/busy/done=%b want 0000",
                     {load, prbs_advance, busy, frame_done});
        else pass_cnt++;
        total_cnt++;
        if (word_out !== 32'd0) $display("FAIL reset_word: got %h want 00000000", word_out);
        else pass_cnt++;
        total_cnt++;
        if (frame_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", frame_count);
        else pass_cnt++;
        rst_n = 1'b1;
        clear_obs();
        run_to(40);
        total_cnt++;
        if (obs_q.size() != 0 || busy_cycles != 0)
            $display("FAIL idle_quiet: got loads=%0d busy_cycles=%0d want 0/0", obs_q.size(), busy_cycles);
        else pass_cnt++;
    endtask

    task automatic test_single_frame();
        load_t o, e;
        do_reset();
        clear_obs();
        payload_len = 8'd3; loop_en = 1'b0;
        push_frame(3);
        launch();
        run_to(225);
        total_cnt++;
        if (busy !== 1'b0 || frame_done !== 1'b1)
            $display("FAIL single_end_225: got busy=%b done=%b want busy=0 done=1", busy, frame_done);
        else pass_cnt++;
        total_cnt++;
        if (frame_count !== 8'd1) $display("FAIL single_count: got %0d want 1", frame_count);
        else pass_cnt++;
        run_to(320);
        total_cnt++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL single_load_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total_cnt++;
            if (o.cyc !== e.cyc || o.word !== e.word || o.adv !== e.adv)
                $display("FAIL single_load: got cyc=%0d word=%h adv=%b want cyc=%0d word=%h adv=%b",
                         o.cyc, o.word, o.adv, e.cyc, e.word, e.adv);
            else pass_cnt++;
        end
        total_cnt++;
        if (done_q.size() != 1 || busy_cycles != 224 || stray_adv != 0)
            $display("FAIL single_done: got dones=%0d busy_cycles=%0d stray_adv=%0d want 1/224/0",
                     done_q.size(), busy_cycles, stray_adv);
        else pass_cnt++;
    endtask

    task automatic test_loop();
        load_t o, e;
        int    want_done[3];
        do_reset();
        clear_obs();
        stop = 1'b1;
        run_to(10);
        stop = 1'b0;
        clear_obs();
        payload_len = 8'd0; loop_en = 1'b1;
        for (int f = 0; f < 3; f++) push_frame(0);
        launch();
        run_to(300);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_to(385);
        total_cnt++;
        if (frame_count !== 8'd3 || busy !== 1'b0)
            $display("FAIL loop_end: got count=%0d busy=%b want count=3 busy=0", frame_count, busy);
        else pass_cnt++;
        run_to(460);
        total_cnt++;
        if (obs_q.size() < 5 || obs_q[4].word !== SYNC_W || obs_q[4].cyc != 129)
            $display("FAIL loop_fifth_load: got n=%0d want SYNC word at cycle 129", obs_q.size());
        else pass_cnt++;
        want_done = '{129, 257, 385};
        total_cnt++;
        if (done_q.size() != 3)
            $display("FAIL loop_done_count: got %0d want 3", done_q.size());
        else pass_cnt++;
        for (int i = 0; i < 3 && i < done_q.size(); i++) begin
            total_cnt++;
            if (done_q[i] != want_done[i])
                $display("FAIL loop_done_cycle: got %0d want %0d", done_q[i], want_done[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL loop_load_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total_cnt++;
            if (o.cyc !== e.cyc || o.word !== e.word || o.adv !== e.adv)
                $display("FAIL loop_load: got cyc=%0d word=%h adv=%b want cyc=%0d word=%h adv=%b",
                         o.cyc, o.word, o.adv, e.cyc, e.word, e.adv);
            else pass_cnt++;
        end
    endtask

    task automatic test_stop();
        load_t o, e;
        do_reset();
        clear_obs();
        payload_len = 8'd3; loop_en = 1'b1;
        push_frame(3);
        launch();
        run_to(70);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_to(400);
        total_cnt++;
        if (done_q.size() != 1 || (done_q.size() == 1 && done_q[0] != 225) || busy_cycles != 224)
            $display("FAIL stop_end: got dones=%0d busy_cycles=%0d want one done at 225, 224 busy",
                     done_q.size(), busy_cycles);
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL stop_load_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total_cnt++;
            if (o.cyc !== e.cyc || o.word !== e.word || o.adv !== e.adv)
                $display("FAIL stop_load: got cyc=%0d word=%h adv=%b want cyc=%0d word=%h adv=%b",
                         o.cyc, o.word, o.adv, e.cyc, e.word, e.adv);
            else pass_cnt++;
        end
    endtask

    task automatic test_ignored_inputs();
        load_t o, e;
        do_reset();
        clear_obs();
        payload_len = 8'd1; loop_en = 1'b1;
        push_frame(1);
        push_frame(0);
        launch();
        run_to(70);
        start = 1'b1;
        payload_len = 8'd0;
        run_to(75);
        start = 1'b0;
        run_to(200);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_to(360);
        total_cnt++;
        if (done_q.size() != 2 || (done_q.size() == 2 && (done_q[0] != 161 || done_q[1] != 289)))
            $display("FAIL ignored_done: got n=%0d want dones at 161 and 289", done_q.size());
        else pass_cnt++;
        total_cnt++;
        if (frame_count !== 8'd2) $display("FAIL ignored_count: got %0d want 2", frame_count);
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL ignored_load_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total_cnt++;
            if (o.cyc !== e.cyc || o.word !== e.word || o.adv !== e.adv)
                $display("FAIL ignored_load: got cyc=%0d word=%h adv=%b want cyc=%0d word=%h adv=%b",
                         o.cyc, o.word, o.adv, e.cyc, e.word, e.adv);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        clear_obs();
        payload_len = 8'd3; loop_en = 1'b1;
        launch();
        run_to(100);
        total_cnt++;
        if (busy !== 1'b1 || word_out === 32'd0)
            $display("FAIL midreset_pre: got busy=%b word=%h want busy=1 word nonzero", busy, word_out);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({load, prbs_advance, busy, frame_done} !== 4'b0000 || word_out !== 32'd0)
            $display("FAIL midreset_outputs: got strobes=%b word=%h want 0000/00000000",
                     {load, prbs_advance, busy, frame_done}, word_out);
        else pass_cnt++;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_obs();
        run_to(200);
        total_cnt++;
        if (obs_q.size() != 0 || busy_cycles != 0 || frame_count !== 8'd0)
            $display("FAIL midreset_after: got loads=%0d busy_cycles=%0d count=%0d want 0/0/0",
                     obs_q.size(), busy_cycles, frame_count);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        clear_obs();
        payload_len = 8'd0; loop_en = 1'b1;
        launch();
        run_to(255 * 128 + 1);
        total_cnt++;
        if (frame_count !== 8'd255) $display("FAIL wrap_count_255: got %0d want 255", frame_count);
        else pass_cnt++;
        run_to(255 * 128 + 10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_to(256 * 128 + 40);
        total_cnt++;
        if (frame_count !== 8'd0) $display("FAIL wrap_count_0: got %0d want 0", frame_count);
        else pass_cnt++;
        total_cnt++;
        if (done_q.size() != 256 || (done_q.size() == 256 && done_q[255] != 256 * 128 + 1))
            $display("FAIL wrap_dones: got n=%0d want 256 ending at %0d", done_q.size(), 256 * 128 + 1);
        else pass_cnt++;
        total_cnt++;
        if (obs_q.size() != 1024) $display("FAIL wrap_loads: got %0d want 1024", obs_q.size());
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        cyc       = 0;
        test_reset();
        test_single_frame();
        test_loop();
        test_stop();
        test_ignored_inputs();
        test_reset_mid_frame();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/prbs_link_sequencer.md
# prbs_link_sequencer

Frame-level controller for the on-chip PRBS serial test link. It replaces the free-running divide-by-32 load strobe with a sequenced one. Each frame is built from 32-bit word slots: sync words, then a programmable number of PRBS payload words, then idle gap words. The block drives the 32:1 serializer's load strobe and word input, and gates the advance of the PRBS generator. Start, stop and loop control come from the chip's dedicated inputs.

## Interface
Parameters:
- SYNC_WORD, 32'hA5A5_5A5A, pattern sent in every sync slot
- SYNC_SLOTS, 2, sync slots per frame (1..15)
- GAP_SLOTS, 1, gap slots per frame (1..15)
- IDLE_WORD, 32'h0000_0000, pattern sent in gap slots

Ports:
- clk  in  1  serializer bit clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; sampled each cycle, acted on only in IDLE
- stop  in  1  level; requests stop at the end of the current frame
- loop_en  in  1  repeat frames back-to-back; latched at each frame start
- payload_len  in  8  number of payload slots minus 1 (1..256 slots); latched at each frame start
- prbs_word  in  32  current PRBS generator output
- prbs_advance  out  1  one-cycle pulse; generator steps to its next word
- load  out  1  one-cycle pulse; serializer captures word_out
- word_out  out  32  word presented to the serializer, valid when load=1
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at the end of each frame
- frame_count  out  8  completed frames, wraps 255→0

## Operation
- States: IDLE, SYNC, PAYLOAD, GAP.
- Slot counter: 5 bits, cleared on entry from IDLE, increments every cycle while busy, wraps 31→0. Slot boundary is slot_cnt==0.
- Slot counter (second counter): counts slots within the current state.
- On every boundary while busy:
  - load=1.
  - word_out = SYNC_WORD in SYNC, prbs_word in PAYLOAD, IDLE_WORD in GAP.
  - prbs_advance=1 in PAYLOAD only.
- Transitions, evaluated at slot_cnt==31:
  - SYNC→PAYLOAD after SYNC_SLOTS slots.
  - PAYLOAD→GAP after payload_len+1 slots.
  - GAP→SYNC after GAP_SLOTS slots if loop_en_latched=1 and stop_pending=0; otherwise GAP→IDLE.
- IDLE→SYNC when start=1. At the same time, latch payload_len and loop_en. Also latch them on every GAP→SYNC transition.
- stop sets stop_pending while busy. stop_pending is cleared on entry to IDLE. stop asserted together with start in IDLE lets exactly one frame run.
- start while busy is ignored. stop while IDLE (without start) is ignored.
- frame_done pulses, and frame_count increments, in the first cycle after the last GAP slot. That cycle is either the first IDLE cycle or the first cycle of the next SYNC slot.
- All outputs are registered.
- Reset values: load=0, prbs_advance=0, word_out=0, busy=0, frame_done=0, frame_count=0. State=IDLE, all counters 0, stop_pending=0.
- Reset asserted mid-frame: outputs go to their reset values immediately, no partial slot completes, and nothing resumes after reset deasserts.

## Timing
- start sampled high at edge E0 → busy=1, load=1 and word_out=SYNC_WORD in the cycle after E0 (cycle 1).
- Slot i begins at cycle 1+32·i. Exactly one load pulse per 32 cycles while busy.
- Frame length = (SYNC_SLOTS + payload_len + 1 + GAP_SLOTS)·32 cycles.
- prbs_advance coincides with load. The generator updates before the next boundary, which is 32 cycles later, so there is no combinational path from prbs_word to word_out beyond one register.
- Back-to-back frames have no dead cycles: the first SYNC load follows the last GAP slot by exactly 32 cycles from that slot's load.

## Structure
- Package prbs_seq_pkg holds:
  - the state enum (IDLE, SYNC, PAYLOAD, GAP);
  - SLOT_BITS=32 and the slot counter width (5);
  - the default SYNC_WORD and IDLE_WORD constants.
- Sub-module slot_timer: 5-bit wrapping counter with clear and enable, outputs boundary (cnt==0) and last (cnt==31). Everything else lives in the top FSM.

## Test plan
- Single frame: payload_len=3, loop_en=0, start at E0:
  - loads at cycles 1, 33, …, 193 (7 loads);
  - words are A5A5_5A5A ×2, four prbs_word values, then 0;
  - prbs_advance on loads 3–6 only;
  - frame_done and busy=0 at cycle 225;
  - frame_count=1.
- Loop: payload_len=0, loop_en=1, run 3 frames:
  - frame_done at cycles 129, 257, 385;
  - the 5th load (cycle 129) is SYNC_WORD;
  - frame_count=3.
- Stop mid-payload: stop asserted at cycle 70 with loop_en=1 → the frame completes through GAP, goes IDLE at cycle 225 (payload_len=3), and no further loads occur.
- Ignored inputs: start pulses during PAYLOAD have no effect on timing. payload_len changed mid-frame only affects the next frame.
- Reset mid-frame: rst_n low at cycle 100 → all outputs 0 the same cycle. After release with start=0, no load for 200 cycles.
- Wrap: 256 looped frames with payload_len=0 → frame_count returns to 0 and frame_done pulses 256 times.
